// File: rtl/product_accumulator_if.sv
// Bundle between a multiplier-result producer and the product accumulator.
// The master drives Start/Mul_Ready/Product/Ack; the slave returns the running sum and status.
interface product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              Start;
  logic              Mul_Ready;
  logic [PROD_W-1:0] Product;
  logic              Ack;
  logic [ACC_W-1:0]  Acc;
  logic [7:0]        Term_Count;
  logic              Busy;
  logic              Done;
  logic              Sat;
  logic              Overrun;

  modport master (
    output Start, Mul_Ready, Product, Ack,
    input  Acc, Term_Count, Busy, Done, Sat, Overrun
  );

  modport slave (
    input  Start, Mul_Ready, Product, Ack,
    output Acc, Term_Count, Busy, Done, Sat, Overrun
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums NUM_TERMS signed multiplier products into a saturating accumulator,
// capturing each product on a rising edge of the multiplier's Ready level.
module product_accumulator #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int NUM_TERMS = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [7:0]       NT      = 8'(NUM_TERMS);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             ovr_q, ovr_d;
  logic             ready_q;

  logic             rise;
  logic             vec_start;
  logic [7:0]       cnt_inc;
  logic [ACC_W:0]   sum;
  logic             clamp;
  logic [ACC_W-1:0] acc_sat;

  assign rise    = bus.Mul_Ready & ~ready_q;
  assign cnt_inc = cnt_q + 8'd1;

  // One guard bit: overflow shows up as the top two sum bits disagreeing.
  always_comb begin
    sum     = {acc_q[ACC_W-1], acc_q}
            + {{(ACC_W+1-PROD_W){bus.Product[PROD_W-1]}}, bus.Product};
    clamp   = sum[ACC_W] ^ sum[ACC_W-1];
    acc_sat = sum[ACC_W-1:0];
    if (clamp) acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
      ready_q <= bus.Mul_Ready;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d   = ACCUM;
          vec_start = 1'b1;
        end
      end
      ACCUM: begin
        if (rise && (cnt_inc == NT)) state_d = HOLD;
      end
      HOLD: begin
        if (bus.Ack) begin
          state_d   = bus.Start ? ACCUM : IDLE;
          vec_start = bus.Start;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new vector's clears take priority over a product edge arriving on the same clock.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    ovr_d = ovr_q;
    if (vec_start) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
      ovr_d = 1'b0;
    end else if (rise) begin
      if (state_q == ACCUM) begin
        acc_d = acc_sat;
        cnt_d = cnt_inc;
        sat_d = sat_q | clamp;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.Acc        = acc_q;
    bus.Term_Count = cnt_q;
    bus.Busy       = (state_q == ACCUM);
    bus.Done       = (state_q == HOLD);
    bus.Sat        = sat_q;
    bus.Overrun    = ovr_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives two accumulator configurations (24-bit/4 terms and 18-bit/5 terms) with
// identical stimulus and compares both against an arithmetic reference model.
module tb_product_accumulator;

  localparam int AW_A = 24;
  localparam int NT_A = 4;
  localparam int AW_B = 18;
  localparam int NT_B = 5;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        mul_ready;
  logic        ack;
  logic [15:0] product;

  always #5 Clk = ~Clk;

  product_accumulator_if #(.PROD_W(16), .ACC_W(AW_A)) ifa ();
  product_accumulator_if #(.PROD_W(16), .ACC_W(AW_B)) ifb ();

  assign ifa.Start     = start;
  assign ifa.Mul_Ready = mul_ready;
  assign ifa.Product   = product;
  assign ifa.Ack       = ack;
  assign ifb.Start     = start;
  assign ifb.Mul_Ready = mul_ready;
  assign ifb.Product   = product;
  assign ifb.Ack       = ack;

  product_accumulator #(.PROD_W(16), .ACC_W(AW_A), .NUM_TERMS(NT_A)) u_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifa)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(AW_B), .NUM_TERMS(NT_B)) u_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifb)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = waiting for Start, 1 = collecting, 2 = holding result.
  longint m_acc  [2];
  int     m_cnt  [2];
  int     m_mode [2];
  bit     m_sat  [2];
  bit     m_ovr  [2];
  bit     m_prev;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m_acc[k] = 0;
    m_cnt[k] = 0;
    m_sat[k] = 0;
    m_ovr[k] = 0;
  endtask

  task automatic model_edge();
    bit     rise;
    longint hi, lo, s;
    int     aw, nt;
    rise = mul_ready && !m_prev;
    for (int k = 0; k < 2; k++) begin
      aw = (k == 0) ? AW_A : AW_B;
      nt = (k == 0) ? NT_A : NT_B;
      hi = (longint'(1) << (aw - 1)) - 1;
      lo = -hi - 1;
      if (Reset) begin
        model_clear(k);
        m_mode[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (start) begin
          model_clear(k);
          m_mode[k] = 1;
        end else if (rise) m_ovr[k] = 1;
      end else if (m_mode[k] == 1) begin
        if (rise) begin
          s = m_acc[k] + longint'($signed(product));
          if (s > hi) begin s = hi; m_sat[k] = 1; end
          if (s < lo) begin s = lo; m_sat[k] = 1; end
          m_acc[k] = s;
          m_cnt[k]++;
          if (m_cnt[k] == nt) m_mode[k] = 2;
        end
      end else begin
        if (start && ack) begin
          model_clear(k);
          m_mode[k] = 1;
        end else begin
          if (rise) m_ovr[k] = 1;
          if (ack)  m_mode[k] = 0;
        end
      end
    end
    m_prev = Reset ? 1'b1 : mul_ready;
  endtask

  task automatic compare_dut(input string p, input int k, input longint acc, input longint cnt,
                             input longint busy, input longint done, input longint sat,
                             input longint ovr);
    check_eq({p, "_acc"},  acc,  m_acc[k]);
    check_eq({p, "_cnt"},  cnt,  longint'(m_cnt[k]));
    check_eq({p, "_busy"}, busy, longint'(m_mode[k] == 1));
    check_eq({p, "_done"}, done, longint'(m_mode[k] == 2));
    check_eq({p, "_sat"},  sat,  longint'(m_sat[k]));
    check_eq({p, "_ovr"},  ovr,  longint'(m_ovr[k]));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare_dut("a", 0, longint'($signed(ifa.Acc)), longint'(ifa.Term_Count), longint'(ifa.Busy),
                longint'(ifa.Done), longint'(ifa.Sat), longint'(ifa.Overrun));
    compare_dut("b", 1, longint'($signed(ifb.Acc)), longint'(ifb.Term_Count), longint'(ifb.Busy),
                longint'(ifb.Done), longint'(ifb.Sat), longint'(ifb.Overrun));
  endtask

  task automatic drive(input logic s, input logic mr, input logic [15:0] p, input logic a);
    start     = s;
    mul_ready = mr;
    product   = p;
    ack       = a;
    tick();
  endtask

  task automatic send(input logic [15:0] p);
    drive(1'b0, 1'b0, p, 1'b0);
    drive(1'b0, 1'b1, p, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    start     = 1'b0;
    mul_ready = 1'b1;
    ack       = 1'b0;
    product   = 16'h0000;
    m_prev    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_mode[k] = 0;
    end

    // Reset with Mul_Ready held high; releasing must not look like a product edge.
    tick();
    tick();
    Reset = 1'b0;
    drive(1'b0, 1'b1, 16'h1234, 1'b0);
    drive(1'b0, 1'b1, 16'h1234, 1'b0);
    check_eq("rst_acc",  longint'(ifa.Acc), 0);
    check_eq("rst_busy", longint'(ifa.Busy), 0);
    check_eq("rst_done", longint'(ifa.Done), 0);
    check_eq("rst_ovr",  longint'(ifa.Overrun), 0);

    // Four copies of 127 x -8.
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      send(16'hFC08);
      check_eq("fc08_cnt", longint'(ifa.Term_Count), longint'(i));
    end
    check_eq("fc08_done", longint'(ifa.Done), 1);
    check_eq("fc08_acc",  longint'(ifa.Acc), longint'(24'hFFF020));
    check_eq("fc08_sat",  longint'(ifa.Sat), 0);

    // Product edge while holding is dropped and flagged.
    send(16'h1234);
    check_eq("hold_acc", longint'(ifa.Acc), longint'(24'hFFF020));
    check_eq("hold_ovr", longint'(ifa.Overrun), 1);

    // Start together with Ack restarts immediately.
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("b2b_busy", longint'(ifa.Busy), 1);
    check_eq("b2b_acc",  longint'(ifa.Acc), 0);
    check_eq("b2b_ovr",  longint'(ifa.Overrun), 0);

    // Mixed signs summing to -1.
    send(16'h03F8);
    send(16'hFC08);
    send(16'h7FFF);
    send(16'h8000);
    check_eq("mix_acc", longint'(ifa.Acc), longint'(24'hFFFFFF));
    check_eq("mix_sat", longint'(ifa.Sat), 0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("ack_done", longint'(ifa.Done), 0);
    check_eq("ack_busy", longint'(ifa.Busy), 0);
    check_eq("ack_acc",  longint'(ifa.Acc), longint'(24'hFFFFFF));

    // Narrow accumulator: positive then negative saturation.
    do_reset();
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) send(16'h7FFF);
    check_eq("bpos_done", longint'(ifb.Done), 1);
    check_eq("bpos_acc",  longint'(ifb.Acc), longint'(18'h1FFFF));
    check_eq("bpos_sat",  longint'(ifb.Sat), 1);
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("bneg_sat_clr", longint'(ifb.Sat), 0);
    for (int i = 0; i < 5; i++) send(16'h8000);
    check_eq("bneg_acc", longint'(ifb.Acc), longint'(18'h20000));
    check_eq("bneg_sat", longint'(ifb.Sat), 1);

    // Reset in the middle of a vector, then a clean vector.
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    send(16'h0100);
    send(16'h0100);
    do_reset();
    check_eq("mid_acc",  longint'(ifa.Acc), 0);
    check_eq("mid_cnt",  longint'(ifa.Term_Count), 0);
    check_eq("mid_busy", longint'(ifa.Busy), 0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) send(16'h0100);
    check_eq("clean_acc",  longint'(ifa.Acc), 1024);
    check_eq("clean_done", longint'(ifa.Done), 1);

    // Randomized traffic, biased toward extreme products and frequent edges.
    for (int n = 0; n < 800; n++) begin
      Reset = ($urandom % 80) == 0;
      drive(($urandom % 6) == 0, 1'($urandom % 2),
            (($urandom % 3) == 0) ? ((($urandom % 2) == 0) ? 16'h7FFF : 16'h8000) : 16'($urandom),
            ($urandom % 3) == 0);
    end
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
